// File: rtl/pixel_frame_pkg.sv
// Shared types and constants for the pixel frame capture path.
package pixel_frame_pkg;
  localparam int PIX_W  = 2;
  localparam int FCNT_W = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    CAPTURE  = 2'd2,
    DONE     = 2'd3
  } state_t;
endpackage

// File: rtl/frame_ram_2p.sv
// Simple dual-port frame RAM: synchronous write, registered read, old data on collision.
module frame_ram_2p #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [0:DEPTH-1];

  // The read samples the array before this edge's write lands.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/pixel_frame_writer.sv
// Captures a raster 2-bit pixel stream into a row-major frame buffer with a coordinate read port.
// Optional macro LINE_CHECK_EN enables the sticky line-length error flag (err_line).
module pixel_frame_writer
  import pixel_frame_pkg::*;
#(
  parameter int frame_width  = 640,
  parameter int frame_height = 480
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [PIX_W-1:0]  s_data,
  input  logic              s_sof,
  input  logic              s_eol,
  input  logic [31:0]       width,
  input  logic [31:0]       height,
  output logic [PIX_W-1:0]  pix_value,
  output logic              busy,
  output logic              done,
  output logic              err_line,
  output logic [FCNT_W-1:0] frame_count
);
  localparam int XW    = (frame_width > 1) ? $clog2(frame_width) : 1;
  localparam int YW    = (frame_height > 1) ? $clog2(frame_height) : 1;
  localparam int DEPTH = frame_width * frame_height;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t          state;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic            acc, we, wr_first, last_x, last_y;
  logic [XW-1:0]   wx;
  logic [YW-1:0]   wy;
  logic [AW-1:0]   waddr, raddr;
  logic            rd_in, rd_ok_p1;
  logic [PIX_W-1:0] ram_q;

  assign acc      = s_valid & s_ready;
  assign we       = acc & ((state == WAIT_SOF & s_sof) | (state == CAPTURE));
  // An SOF beat always lands at (0,0), whether it opens or resyncs a frame.
  assign wr_first = (state == WAIT_SOF) | s_sof;
  assign wx       = wr_first ? '0 : x;
  assign wy       = wr_first ? '0 : y;
  assign waddr    = AW'(wy) * AW'(frame_width) + AW'(wx);
  assign last_x   = (x == XW'(frame_width - 1));
  assign last_y   = (y == YW'(frame_height - 1));

  assign rd_in = (width < 32'(frame_width)) && (height < 32'(frame_height));
  assign raddr = rd_in ? AW'(height[YW-1:0]) * AW'(frame_width) + AW'(width[XW-1:0]) : '0;

  frame_ram_2p #(.DEPTH(DEPTH), .AW(AW), .DW(PIX_W)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (s_data),
    .raddr (raddr),
    .rdata (ram_q)
  );

  // Read stage p1: range flag travels with the RAM read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_ok_p1 <= 1'b0;
    else        rd_ok_p1 <= rd_in;
  end

  assign pix_value = rd_ok_p1 ? ram_q : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      x           <= '0;
      y           <= '0;
      s_ready     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      frame_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= WAIT_SOF;
            s_ready <= 1'b1;
            busy    <= 1'b1;
            x       <= '0;
            y       <= '0;
          end
        end
        WAIT_SOF: begin
          if (acc && s_sof) begin
            state <= CAPTURE;
            x     <= XW'(1);
            y     <= '0;
          end
        end
        CAPTURE: begin
          if (acc) begin
            if (s_sof) begin
              x <= XW'(1);
              y <= '0;
            end else if (last_x) begin
              x <= '0;
              if (last_y) begin
                state       <= DONE;
                s_ready     <= 1'b0;
                busy        <= 1'b0;
                done        <= 1'b1;
                frame_count <= frame_count + 1'b1;
                y           <= '0;
              end else begin
                y <= y + YW'(1);
              end
            end else begin
              x <= x + XW'(1);
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LINE_CHECK_EN
  logic line_bad;
  assign line_bad = we & (s_eol != (wx == XW'(frame_width - 1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      err_line <= 1'b0;
    else if (state == IDLE && start) err_line <= 1'b0;
    else if (line_bad)               err_line <= 1'b1;
  end
`else
  logic unused_eol;
  assign unused_eol = s_eol;
  assign err_line   = 1'b0;
`endif
endmodule

// File: tb/tb_pixel_frame_writer.sv
// Scoreboard bench for pixel_frame_writer on a 4x3 frame.
module tb_pixel_frame_writer;
  localparam int FW = 4;
  localparam int FH = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_sof = 1'b0;
  logic        s_eol = 1'b0;
  logic [1:0]  s_data = '0;
  logic [31:0] width = '0;
  logic [31:0] height = '0;
  logic        s_ready, busy, done, err_line;
  logic [1:0]  pix_value;
  logic [15:0] frame_count;

  always #5 clk = ~clk;

  pixel_frame_writer #(.frame_width(FW), .frame_height(FH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_sof       (s_sof),
    .s_eol       (s_eol),
    .width       (width),
    .height      (height),
    .pix_value   (pix_value),
    .busy        (busy),
    .done        (done),
    .err_line    (err_line),
    .frame_count (frame_count)
  );

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  // Reference model: buffer, write position, and capture state (0 idle, 1 wait sof, 2 capture).
  logic [1:0] mdl [FH][FW];
  int mstate = 0, mx = 0, my = 0, mfc = 0;
  bit merr = 1'b0;
  logic [1:0] exp_q [$];

  always @(negedge clk) if (rst_n && done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic pop_read(input string tag);
    logic [1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(tag, 32'(pix_value), 32'(e));
    end
  endtask

  function automatic logic [1:0] model_px(input int w, input int h);
    if (w >= 0 && w < FW && h >= 0 && h < FH) return mdl[h][w];
    return 2'd0;
  endfunction

  task automatic rd(input logic [31:0] w, input logic [31:0] h, input logic [1:0] e);
    @(negedge clk);
    width  = w;
    height = h;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    pop_read($sformatf("rd(%0h,%0h)", w, h));
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (mstate == 0) begin
      mstate = 1;
      merr   = 1'b0;
    end
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("ready_after_start", 32'(s_ready), 32'd1);
    chk("err_after_start", 32'(err_line), 32'(merr));
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    mstate = 0; mx = 0; my = 0; mfc = 0; merr = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ready"}, 32'(s_ready), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err_line), 32'd0);
    chk({tag, "_pix"}, 32'(pix_value), 32'd0);
    chk({tag, "_fcnt"}, 32'(frame_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [1:0] d, input bit sof, input bit bad_eol, input int gap);
    int px, w;
    bit fin;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    px      = (mstate == 1 || sof) ? 0 : mx;
    s_valid = 1'b1;
    s_data  = d;
    s_sof   = sof;
    s_eol   = (px == FW - 1) ^ bad_eol;
    w = 0;
    while (!s_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!s_ready) begin
      chk("ready_timeout", 32'd0, 32'd1);
      s_valid = 1'b0;
      return;
    end
    @(posedge clk);
    fin = 1'b0;
    if (mstate == 2 || (mstate == 1 && sof)) begin
      if (sof) begin
        mdl[0][0] = d; mx = 1; my = 0; mstate = 2;
      end else begin
        mdl[my][mx] = d;
        if (mx == FW - 1) begin
          mx = 0;
          if (my == FH - 1) begin
            my = 0; fin = 1'b1; mfc++; mstate = 0;
          end else my++;
        end else mx++;
      end
`ifdef LINE_CHECK_EN
      if (bad_eol) merr = 1'b1;
`endif
    end
    #1;
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_eol   = 1'b0;
    chk("done", 32'(done), 32'(fin));
    chk("err_line", 32'(err_line), 32'(merr));
    pop_read("rd_collide");
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] oldv, newv;
    int saved_done;
    for (int h = 0; h < FH; h++) for (int w = 0; w < FW; w++) mdl[h][w] = 2'd0;

    // Reset state
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(s_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err_line), 32'd0);
    chk("rst_pix", 32'(pix_value), 32'd0);
    chk("rst_fcnt", 32'(frame_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic frame: data = index mod 4
    do_start();
    for (int i = 0; i < 12; i++) send(2'(i % 4), i == 0, 1'b0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("f1_done_cnt", 32'(done_cnt), 32'd1);
    chk("f1_fcnt", 32'(frame_count), 32'(mfc));
    chk("f1_busy", 32'(busy), 32'd0);
    chk("f1_ready", 32'(s_ready), 32'd0);
    rd(3, 2, 2'd3);
    for (int h = 0; h < FH; h++) for (int w = 0; w < FW; w++) rd(w, h, model_px(w, h));

    // Pre-SOF beats discarded, then a frame with valid every other cycle
    do_start();
    send(2'd3, 1'b0, 1'b0, 0);
    send(2'd2, 1'b0, 1'b0, 0);
    send(2'd3, 1'b0, 1'b0, 0);
    for (int i = 0; i < 12; i++) send(2'((i + 1) % 4), i == 0, 1'b0, (i == 0) ? 0 : 1);
    rd(0, 0, 2'd1);
    chk("f2_done_cnt", 32'(done_cnt), 32'd2);
    chk("f2_fcnt", 32'(frame_count), 32'd2);

    // Resync on the 6th beat
    do_start();
    for (int i = 0; i < 17; i++)
      send((i < 5) ? 2'd1 : ((i == 5) ? 2'd2 : 2'(i % 4)), (i == 0) || (i == 5), 1'b0, 0);
    rd(0, 0, 2'd2);
    chk("f3_done_cnt", 32'(done_cnt), 32'd3);
    for (int h = 0; h < FH; h++) for (int w = 0; w < FW; w++) rd(w, h, model_px(w, h));

    // Misplaced end-of-line at x=2 on line 0
    do_start();
    for (int i = 0; i < 12; i++) send(2'((i * 3) % 4), i == 0, i == 2, 0);
    @(posedge clk);
    #1;
    chk("f4_err_held", 32'(err_line), 32'(merr));
    chk("f4_done_cnt", 32'(done_cnt), 32'd4);
    do_start();

    // Range check and read/write collision
    rd(4, 0, 2'd0);
    rd(0, 3, 2'd0);
    rd(32'h8000_0001, 1, 2'd0);
    for (int i = 0; i < 5; i++) send(2'(i % 4), i == 0, 1'b0, 0);
    oldv = mdl[1][1];
    newv = ~oldv;
    width  = 1;
    height = 1;
    exp_q.push_back(oldv);
    send(newv, 1'b0, 1'b0, 0);
    rd(1, 1, newv);

    // Reset in the middle of a frame
    saved_done = done_cnt;
    do_reset("mid1");
    do_start();
    for (int i = 0; i < 5; i++) send(2'((i + 2) % 4), i == 0, 1'b0, 0);
    do_reset("mid2");
    repeat (2) @(posedge clk);
    #1;
    chk("mid_done_cnt", 32'(done_cnt), 32'(saved_done));
    chk("mid_fcnt", 32'(frame_count), 32'd0);
    chk("mid_ready", 32'(s_ready), 32'd0);
    rd(0, 1, model_px(0, 1));
    rd(1, 1, model_px(1, 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
